// File: rtl/speck_pkg.sv
// SPECK128/128 shared constants, state encoding and rotate helpers.
// Imported by speck_round and speck_encrypt_core.
package speck_pkg;

  localparam int WORD_W     = 64;
  localparam int ALPHA      = 8;
  localparam int BETA       = 3;
  localparam int ROUNDS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1
  } state_t;

  function automatic logic [WORD_W-1:0] ror(
    input logic [WORD_W-1:0] v,
    input int                n
  );
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] rol(
    input logic [WORD_W-1:0] v,
    input int                n
  );
    return (v << n) | (v >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/speck_round.sv
// One combinational SPECK round: x'=(ROR(x,8)+y)^k, y'=ROL(y,3)^x'.
// Ports: i_x, i_y, i_k (64b) in; o_x, o_y (64b) out.
module speck_round
  import speck_pkg::*;
(
  input  logic [WORD_W-1:0] i_x,
  input  logic [WORD_W-1:0] i_y,
  input  logic [WORD_W-1:0] i_k,
  output logic [WORD_W-1:0] o_x,
  output logic [WORD_W-1:0] o_y
);

  logic [WORD_W-1:0] w_x;

  assign w_x = (ror(i_x, ALPHA) + i_y) ^ i_k;
  assign o_x = w_x;
  assign o_y = rol(i_y, BETA) ^ w_x;

endmodule

// File: rtl/speck_encrypt_core.sv
// Iterative SPECK128/128 encryptor, one round per clock.
// Ports: clk, rst (async high), start, key, plaintext in;
//        ciphertext, done (pulse), busy, state_response out.
module speck_encrypt_core
  import speck_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic [127:0] ciphertext,
  output logic         done,
  output logic         busy,
  output logic [1:0]   state_response
);

  state_t r_state;
  state_t w_state_nxt;

  logic [WORD_W-1:0] r_x, r_y, r_k, r_l;
  logic [5:0]        r_i;
  logic [127:0]      r_ct;
  logic              r_done;

  logic [WORD_W-1:0] w_x, w_y, w_k, w_l;
  logic              w_last;

  assign w_last = (r_i == 6'(ROUNDS - 1));

  speck_round u_data (
    .i_x (r_x),
    .i_y (r_y),
    .i_k (r_k),
    .o_x (w_x),
    .o_y (w_y)
  );

  // Key schedule reuses the round with the counter as round key.
  speck_round u_key (
    .i_x (r_l),
    .i_y (r_k),
    .i_k ({58'b0, r_i}),
    .o_x (w_l),
    .o_y (w_k)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    w_state_nxt = start ? ROUND : IDLE;
      ROUND:   w_state_nxt = w_last ? IDLE : ROUND;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_k    <= '0;
      r_l    <= '0;
      r_i    <= '0;
      r_ct   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x <= plaintext[127:64];
            r_y <= plaintext[63:0];
            r_l <= key[127:64];
            r_k <= key[63:0];
            r_i <= '0;
          end
        end
        ROUND: begin
          r_x <= w_x;
          r_y <= w_y;
          r_l <= w_l;
          r_k <= w_k;
          r_i <= r_i + 6'd1;
          if (w_last) begin
            r_ct   <= {w_x, w_y};
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ciphertext     = r_ct;
  assign done           = r_done;
  assign busy           = (r_state == ROUND);
  assign state_response = r_state;

endmodule

// File: tb/tb_speck_encrypt_core.sv
// Scoreboard bench for speck_encrypt_core (ROUNDS=32 and ROUNDS=1).
// Expected ciphertexts come from an in-bench SPECK128/128 model.
module tb_speck_encrypt_core;

  localparam logic [127:0] KEY0 = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] PT0  = 128'h6c61766975716520_7469206564616d20;
  localparam logic [127:0] CT0  = 128'ha65d985179783265_7860fedf5c570d18;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key, pt;
  logic [127:0] ct;
  logic         done, busy;
  logic [1:0]   st;

  logic         s1_start;
  logic [127:0] s1_key, s1_pt;
  logic [127:0] s1_ct;
  logic         s1_done, s1_busy;
  logic [1:0]   s1_st;

  logic [127:0] sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  speck_encrypt_core #(.ROUNDS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key),
    .plaintext(pt), .ciphertext(ct), .done(done),
    .busy(busy), .state_response(st)
  );

  speck_encrypt_core #(.ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .key(s1_key),
    .plaintext(s1_pt), .ciphertext(s1_ct), .done(s1_done),
    .busy(s1_busy), .state_response(s1_st)
  );

  function automatic logic [127:0] model(
    input logic [127:0] k_in,
    input logic [127:0] p_in,
    input int           rounds
  );
    logic [63:0] x, y, k, l;
    x = p_in[127:64];
    y = p_in[63:0];
    l = k_in[127:64];
    k = k_in[63:0];
    for (int i = 0; i < rounds; i++) begin
      x = ({x[7:0], x[63:8]} + y) ^ k;
      y = {y[60:0], y[63:61]} ^ x;
      l = ({l[7:0], l[63:8]} + k) ^ 64'(i);
      k = {k[60:0], k[63:61]} ^ l;
    end
    return {x, y};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard monitor: every done pops one expected block.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (done && busy) begin
        errors++;
        $display("FAIL done_and_busy at %0t", $time);
      end
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_done at %0t ct=%h", $time, ct);
        end else begin
          logic [127:0] exp;
          exp = sb.pop_front();
          if (ct !== exp) begin
            errors++;
            $display("FAIL sb_ciphertext got %h exp %h", ct, exp);
          end
        end
      end
    end
  end

  task automatic send(input logic [127:0] k, input logic [127:0] p);
    start = 1'b1;
    key   = k;
    pt    = p;
    sb.push_back(model(k, p, 32));
    @(posedge clk);
    #1;
    start = 1'b0;
    key   = rnd128();
    pt    = rnd128();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 100);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    key = '0;
    pt = '0;
    s1_start = 1'b0;
    s1_key = '0;
    s1_pt = '0;
    #13;
    checks++;
    if (ct !== '0 || done !== 1'b0 || busy !== 1'b0 || st !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got ct=%h d=%b b=%b st=%0d exp 0", ct, done, busy, st);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_vector();
    int n;
    send(KEY0, PT0);
    checks++;
    if (st !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL vec_state got st=%0d busy=%b exp 1 1", st, busy);
    end
    wait_done(n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL vec_latency got %0d exp 32", n);
    end
    checks++;
    if (ct !== CT0) begin
      errors++;
      $display("FAIL vec_ciphertext got %h exp %h", ct, CT0);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start = 1'b1;
    key   = KEY0;
    pt    = PT0;
    for (int b = 0; b < 3; b++) begin
      sb.push_back(model(KEY0, PT0, 32));
      @(posedge clk);
      #1;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
        if (!done && busy !== 1'b1) begin
          checks++;
          errors++;
          $display("FAIL b2b_busy_low block %0d cycle %0d", b, n);
        end
      end while (!done && n < 100);
      checks++;
      if (n !== 32 || busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_latency block %0d got %0d busy=%b exp 32 0", b, n, busy);
      end
      checks++;
      if (ct !== CT0) begin
        errors++;
        $display("FAIL b2b_ciphertext got %h exp %h", ct, CT0);
      end
      if (b == 2) start = 1'b0;
    end
  endtask

  task automatic test_ignore_start();
    int n;
    send(KEY0, PT0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    key   = ~KEY0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 22) begin
      errors++;
      $display("FAIL ignore_latency got %0d exp 22", n);
    end
    checks++;
    if (ct !== CT0) begin
      errors++;
      $display("FAIL ignore_ciphertext got %h exp %h", ct, CT0);
    end
    repeat (40) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL ignore_queued got done=%b busy=%b exp 0 0", done, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    send(KEY0, PT0);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if (ct !== '0 || done !== 1'b0 || busy !== 1'b0 || st !== 2'd0) begin
      errors++;
      $display("FAIL midreset_state got ct=%h d=%b b=%b st=%0d exp 0", ct, done, busy, st);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || ct !== '0) begin
        errors++;
        $display("FAIL midreset_done got done=%b ct=%h exp 0", done, ct);
      end
    end
    test_vector();
  endtask

  task automatic test_rounds1();
    logic [127:0] k, p, exp;
    for (int t = 0; t < 2; t++) begin
      k = (t == 0) ? '0 : rnd128();
      p = (t == 0) ? '0 : rnd128();
      exp = model(k, p, 1);
      s1_start = 1'b1;
      s1_key   = k;
      s1_pt    = p;
      @(posedge clk);
      #1;
      s1_start = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (s1_done !== 1'b1 || s1_ct !== exp) begin
        errors++;
        $display("FAIL r1_result got done=%b ct=%h exp 1 %h", s1_done, s1_ct, exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if (s1_done !== 1'b0 || s1_ct !== exp) begin
        errors++;
        $display("FAIL r1_hold got done=%b ct=%h exp 0 %h", s1_done, s1_ct, exp);
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 1000; t++) begin
      send(rnd128(), rnd128());
      wait_done(n);
      checks++;
      if (n !== 32) begin
        errors++;
        $display("FAIL rand_latency iter %0d got %0d exp 32", t, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vector();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_rounds1();
    test_random();
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
